// File: rtl/ipic_lite_responder_if.sv
// Lite IPIC single-beat master bus: initiator drives ip2bus_*, responder answers on bus2ip_*.
interface ipic_lite_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      ip2bus_mstrd_req;
  logic                      ip2bus_mstwr_req;
  logic [ADDR_WIDTH-1:0]     ip2bus_mst_addr;
  logic [DATA_WIDTH/8-1:0]   ip2bus_mst_be;
  logic                      ip2bus_mst_lock;
  logic                      ip2bus_mst_reset;
  logic [DATA_WIDTH-1:0]     ip2bus_mstwr_d;
  logic                      bus2ip_mst_cmdack;
  logic                      bus2ip_mst_cmplt;
  logic                      bus2ip_mst_error;
  logic                      bus2ip_mst_rearbitrate;
  logic                      bus2ip_mst_cmd_timeout;
  logic [DATA_WIDTH-1:0]     bus2ip_mstrd_d;
  logic                      bus2ip_mstrd_src_rdy_n;
  logic                      bus2ip_mstwr_dst_rdy_n;

  modport master (
    output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mst_rearbitrate,
           bus2ip_mst_cmd_timeout, bus2ip_mstrd_d, bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );

  modport slave (
    input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mst_rearbitrate,
           bus2ip_mst_cmd_timeout, bus2ip_mstrd_d, bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );
endinterface

// File: rtl/ipic_lite_responder.sv
// Lite IPIC responder: answers single read/write requests from a word-addressed
// register bank with programmable completion latency, plus a registered side read port.
module ipic_lite_responder #(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned          NUM_WORDS    = 16,
  parameter int unsigned          RESP_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ipic_lite_responder_if.slave          bus,
  input  logic [$clog2(NUM_WORDS)-1:0]  usr_rd_addr,
  output logic [DATA_WIDTH-1:0]         usr_rd_data,
  output logic                          busy
);

  localparam int unsigned           IDX_W   = $clog2(NUM_WORDS);
  localparam int unsigned           BE_W    = DATA_WIDTH / 8;
  localparam int unsigned           CNT_W   = 4;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(NUM_WORDS);
  localparam logic [CNT_W-1:0]      LAT     = CNT_W'(RESP_LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_XFER, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q, err_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BE_W-1:0]         be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   bank [NUM_WORDS];

  logic                    req_c, err_c, accept_c, wr_en_c;
  logic [ADDR_WIDTH-1:0]   off_c;
  logic [DATA_WIDTH-1:0]   mask_c;
  logic                    cmdack_nxt, cmplt_nxt, error_nxt, src_rdy_n_nxt, dst_rdy_n_nxt, rd_load_nxt;
  logic                    unused_lock_c;

  // Request decode; an out-of-window, unaligned or ambiguous request completes with error
  assign req_c    = bus.ip2bus_mstrd_req | bus.ip2bus_mstwr_req;
  assign off_c    = bus.ip2bus_mst_addr - BASE_ADDR;
  assign err_c    = (bus.ip2bus_mstrd_req & bus.ip2bus_mstwr_req)
                  | (bus.ip2bus_mst_addr < BASE_ADDR)
                  | ((off_c >> 2) >= DEPTH_A)
                  | (bus.ip2bus_mst_addr[1:0] != 2'b00);
  assign accept_c = (state_q == S_IDLE) && (state_d == S_ACK);
  assign wr_en_c  = (state_q == S_XFER) && wr_q && !err_q && !bus.ip2bus_mst_reset;

  assign unused_lock_c              = bus.ip2bus_mst_lock;
  assign bus.bus2ip_mst_rearbitrate = 1'b0;
  assign bus.bus2ip_mst_cmd_timeout = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort wins from any state
  always_comb begin
    state_d = state_q;
    if (bus.ip2bus_mst_reset) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_c) state_d = S_ACK;
        S_ACK:  state_d = (LAT == '0) ? S_XFER : S_WAIT;
        S_WAIT: if (cnt_q <= CNT_W'(1)) state_d = S_XFER;
        S_XFER: state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every strobe leaves a flop
  always_comb begin
    cmdack_nxt    = 1'b0;
    cmplt_nxt     = 1'b0;
    error_nxt     = 1'b0;
    src_rdy_n_nxt = 1'b1;
    dst_rdy_n_nxt = 1'b1;
    rd_load_nxt   = 1'b0;
    if (state_d == S_ACK) cmdack_nxt = 1'b1;
    if (state_d == S_XFER) begin
      cmplt_nxt = 1'b1;
      error_nxt = err_q;
      if (wr_q) begin
        dst_rdy_n_nxt = 1'b0;
      end else begin
        src_rdy_n_nxt = 1'b0;
        rd_load_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.bus2ip_mst_cmdack      <= 1'b0;
      bus.bus2ip_mst_cmplt       <= 1'b0;
      bus.bus2ip_mst_error       <= 1'b0;
      bus.bus2ip_mstrd_src_rdy_n <= 1'b1;
      bus.bus2ip_mstwr_dst_rdy_n <= 1'b1;
      bus.bus2ip_mstrd_d         <= '0;
      busy                       <= 1'b0;
    end else begin
      bus.bus2ip_mst_cmdack      <= cmdack_nxt;
      bus.bus2ip_mst_cmplt       <= cmplt_nxt;
      bus.bus2ip_mst_error       <= error_nxt;
      bus.bus2ip_mstrd_src_rdy_n <= src_rdy_n_nxt;
      bus.bus2ip_mstwr_dst_rdy_n <= dst_rdy_n_nxt;
      busy                       <= (state_d != S_IDLE);
      // Read data is held past cmplt because the initiator samples it a cycle late
      if (rd_load_nxt) bus.bus2ip_mstrd_d <= err_q ? '0 : bank[idx_q];
    end
  end

  // Request capture and latency counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept_c) begin
        wr_q    <= bus.ip2bus_mstwr_req & ~bus.ip2bus_mstrd_req;
        err_q   <= err_c;
        idx_q   <= off_c[IDX_W+1:2];
        be_q    <= bus.ip2bus_mst_be;
        wdata_q <= bus.ip2bus_mstwr_d;
      end
      if (state_q == S_ACK)       cnt_q <= LAT;
      else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    mask_c = '0;
    for (int unsigned b = 0; b < BE_W; b++) mask_c[8*b +: 8] = {8{be_q[b]}};
  end

  // Register bank, written at the end of the completion cycle
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    always_ff @(posedge clk) begin
      if (!reset_n)                                bank[w] <= '0;
      else if (wr_en_c && (idx_q == IDX_W'(w)))    bank[w] <= (bank[w] & ~mask_c) | (wdata_q & mask_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) usr_rd_data <= '0;
    else          usr_rd_data <= bank[usr_rd_addr];
  end

endmodule

// File: tb/tb_ipic_lite_responder.sv
// Scoreboard bench for ipic_lite_responder: one instance at latency 2, one at latency 0.
module tb_ipic_lite_responder;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NW   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct {
    int          cyc;
    logic        wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req, wr_req, lock, mst_reset, sel0;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [3:0]  usr_rd_addr;
  logic [31:0] usr0, usr2;
  logic        busy0, busy2;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          next_free = 0;
  exp_t        cpl_q[$];
  int          ack_q[$];
  logic [31:0] mdl [2][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ipic_lite_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  ipic_lite_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();

  assign b0.ip2bus_mstrd_req = rd_req & sel0;
  assign b0.ip2bus_mstwr_req = wr_req & sel0;
  assign b0.ip2bus_mst_reset = mst_reset & sel0;
  assign b0.ip2bus_mst_addr  = addr;
  assign b0.ip2bus_mst_be    = be;
  assign b0.ip2bus_mst_lock  = lock;
  assign b0.ip2bus_mstwr_d   = wdata;
  assign b2.ip2bus_mstrd_req = rd_req & ~sel0;
  assign b2.ip2bus_mstwr_req = wr_req & ~sel0;
  assign b2.ip2bus_mst_reset = mst_reset & ~sel0;
  assign b2.ip2bus_mst_addr  = addr;
  assign b2.ip2bus_mst_be    = be;
  assign b2.ip2bus_mst_lock  = lock;
  assign b2.ip2bus_mstwr_d   = wdata;

  ipic_lite_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
                        .NUM_WORDS(NW), .RESP_LATENCY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave),
    .usr_rd_addr(usr_rd_addr), .usr_rd_data(usr0), .busy(busy0));

  ipic_lite_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
                        .NUM_WORDS(NW), .RESP_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave),
    .usr_rd_addr(usr_rd_addr), .usr_rd_data(usr2), .busy(busy2));

  logic        m_ack, m_cpl, m_err, m_src, m_dst, m_busy, m_rearb, m_tmo;
  logic [31:0] m_rdd, m_usr;
  assign m_ack   = sel0 ? b0.bus2ip_mst_cmdack      : b2.bus2ip_mst_cmdack;
  assign m_cpl   = sel0 ? b0.bus2ip_mst_cmplt       : b2.bus2ip_mst_cmplt;
  assign m_err   = sel0 ? b0.bus2ip_mst_error       : b2.bus2ip_mst_error;
  assign m_src   = sel0 ? b0.bus2ip_mstrd_src_rdy_n : b2.bus2ip_mstrd_src_rdy_n;
  assign m_dst   = sel0 ? b0.bus2ip_mstwr_dst_rdy_n : b2.bus2ip_mstwr_dst_rdy_n;
  assign m_rdd   = sel0 ? b0.bus2ip_mstrd_d         : b2.bus2ip_mstrd_d;
  assign m_rearb = sel0 ? b0.bus2ip_mst_rearbitrate : b2.bus2ip_mst_rearbitrate;
  assign m_tmo   = sel0 ? b0.bus2ip_mst_cmd_timeout : b2.bus2ip_mst_cmd_timeout;
  assign m_busy  = sel0 ? busy0 : busy2;
  assign m_usr   = sel0 ? usr0  : usr2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every cmdack/cmplt must match a queued expectation
  always @(negedge clk) begin
    exp_t e;
    int   ea;
    if (reset_n) begin
      if (m_ack) begin
        if (ack_q.size() == 0) check("cmdack_unexpected", 32'(m_ack), 32'd0);
        else begin
          ea = ack_q.pop_front();
          check("cmdack_cycle", 32'(cyc), 32'(ea));
        end
      end
      if (m_cpl) begin
        if (cpl_q.size() == 0) check("cmplt_unexpected", 32'(m_cpl), 32'd0);
        else begin
          e = cpl_q.pop_front();
          check("cmplt_cycle", 32'(cyc), 32'(e.cyc));
          check("error", 32'(m_err), 32'(e.err));
          if (e.wr) begin
            check("dst_rdy_n", 32'(m_dst), 32'd0);
            check("src_rdy_n_idle", 32'(m_src), 32'd1);
          end else begin
            check("src_rdy_n", 32'(m_src), 32'd0);
            check("dst_rdy_n_idle", 32'(m_dst), 32'd1);
            check("rd_data", m_rdd, e.data);
          end
        end
      end
    end
  end

  // Drive a request and queue what the responder must return for it
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit expect_cpl);
    int          k, rl, s;
    logic        e;
    logic [31:0] off;
    exp_t        x;
    k   = sel0 ? 0 : 1;
    rl  = sel0 ? 0 : 2;
    off = a - BASE;
    e   = (rd && wr) || (a < BASE) || ((off >> 2) >= 32'(NW)) || (a[1:0] != 2'b00);
    s   = (cyc > next_free) ? cyc : next_free;
    ack_q.push_back(s + 1);
    if (expect_cpl) begin
      x.cyc  = s + 2 + rl;
      x.wr   = wr && !rd;
      x.err  = e;
      x.data = (e || x.wr) ? 32'd0 : mdl[k][off[5:2]];
      cpl_q.push_back(x);
      if (x.wr && !e)
        for (int i = 0; i < 4; i++) if (b[i]) mdl[k][off[5:2]][8*i +: 8] = d[8*i +: 8];
    end
    next_free = s + 4 + rl;
    rd_req = rd; wr_req = wr; addr = a; be = b; wdata = d;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_ack && n < 50);
    if (!m_ack) check("cmdack_timeout", 32'(m_ack), 32'd1);
  endtask

  task automatic release_req();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || cpl_q.size() != 0) && n < 50) begin @(negedge clk); n++; end
    if (m_busy || cpl_q.size() != 0) check("idle_timeout", 32'(cpl_q.size()), 32'd0);
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    issue(rd, wr, a, b, d, 1'b1);
    wait_ack();
    release_req();
    wait_idle();
  endtask

  task automatic side_check(input int idx, input logic [31:0] exp);
    usr_rd_addr = 4'(idx);
    @(negedge clk);
    check("side_port", m_usr, exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmdack", 32'(m_ack), 32'd0);
    check("rst_cmplt", 32'(m_cpl), 32'd0);
    check("rst_error", 32'(m_err), 32'd0);
    check("rst_src_rdy_n", 32'(m_src), 32'd1);
    check("rst_dst_rdy_n", 32'(m_dst), 32'd1);
    check("rst_mstrd_d", m_rdd, 32'd0);
    check("rst_usr_rd_data", m_usr, 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("tie_rearb", 32'(m_rearb), 32'd0);
    check("tie_timeout", 32'(m_tmo), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) mdl[k][i] = 32'd0;
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; lock = 1'b0; mst_reset = 1'b0;
    sel0 = 1'b0; addr = '0; be = '0; wdata = '0; usr_rd_addr = 4'd2;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);
    next_free = cyc;

    // Latency-2 instance: full write, readback, data hold, partial write
    txn(1'b0, 1'b1, BASE + 32'h8, 4'hF, 32'hDEAD_BEEF);
    side_check(2, 32'hDEAD_BEEF);
    txn(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
    @(negedge clk);
    check("rd_hold", m_rdd, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, BASE + 32'h8, 4'b0101, 32'h1122_3344);
    side_check(2, 32'hDE22_BE44);
    txn(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);

    // Error cases: above window, unaligned, below base, simultaneous rd+wr
    txn(1'b1, 1'b0, BASE + 32'(4*NW), 4'hF, 32'h0);
    txn(1'b0, 1'b1, BASE + 32'h5, 4'hF, 32'hFFFF_FFFF);
    txn(1'b1, 1'b0, BASE - 32'h4, 4'hF, 32'h0);
    txn(1'b1, 1'b1, BASE + 32'h8, 4'hF, 32'h5555_5555);
    side_check(1, 32'h0);
    side_check(2, 32'hDE22_BE44);

    // Last word of the window is legal
    txn(1'b0, 1'b1, BASE + 32'(4*(NW-1)), 4'hF, 32'h0BAD_F00D);
    txn(1'b1, 1'b0, BASE + 32'(4*(NW-1)), 4'hF, 32'h0);

    // Abort during the wait phase of a write
    txn(1'b0, 1'b1, BASE + 32'hC, 4'hF, 32'hCAFE_0003);
    issue(1'b0, 1'b1, BASE + 32'hC, 4'hF, 32'h1234_5678, 1'b0);
    wait_ack();
    release_req();
    @(negedge clk);
    mst_reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(m_busy), 32'd0);
    mst_reset = 1'b0;
    next_free = cyc;
    repeat (4) @(negedge clk);
    side_check(3, 32'hCAFE_0003);

    // Latency-0 instance: back-to-back, second request held from the ack cycle
    sel0 = 1'b1;
    @(negedge clk);
    next_free = cyc;
    issue(1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hA5A5_A5A5, 1'b1);
    wait_ack();
    issue(1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 1'b1);
    wait_ack();
    release_req();
    wait_idle();
    side_check(4, 32'hA5A5_A5A5);

    // Synchronous reset mid-transaction on the latency-2 instance
    sel0 = 1'b0;
    @(negedge clk);
    next_free = cyc;
    txn(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
    issue(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0);
    wait_ack();
    release_req();
    usr_rd_addr = 4'd2;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    ack_q.delete();
    cpl_q.delete();
    for (int i = 0; i < 16; i++) mdl[1][i] = 32'd0;
    reset_n = 1'b1;
    @(negedge clk);
    next_free = cyc;
    txn(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
    side_check(3, 32'h0);

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(ack_q.size() + cpl_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipic_lite_responder.md
Name: ipic_lite_responder

Overview:
- Responder end of the lite IPIC master interface: accepts the single-read/single-write requests our IPIC initiator issues (ip2bus_* signals) and answers with cmdack/cmplt/data/error on bus2ip_*.
- Backs the requests with an internal word-addressed register bank.
- Used as the bus-side endpoint in simulation and as a local scratch/config register target in the middleware; also exposes a side read port for user logic.

Parameters:
- ADDR_WIDTH, 32, IPIC address width.
- DATA_WIDTH, 32, data width; only 32 supported (4 byte enables).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NUM_WORDS, 16, register bank depth in 32-bit words (power of 2, >=2).
- RESP_LATENCY, 2, wait cycles between cmdack and completion (0..15).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ip2bus_mstrd_req  in  1  single-read request
- ip2bus_mstwr_req  in  1  single-write request
- ip2bus_mst_addr  in  ADDR_WIDTH  byte address
- ip2bus_mst_be  in  DATA_WIDTH/8  byte enables
- ip2bus_mst_lock  in  1  ignored
- ip2bus_mst_reset  in  1  transaction abort
- ip2bus_mstwr_d  in  DATA_WIDTH  write data
- bus2ip_mst_cmdack  out  1  command accepted pulse
- bus2ip_mst_cmplt  out  1  transaction complete pulse
- bus2ip_mst_error  out  1  error qualifier, valid with cmplt
- bus2ip_mst_rearbitrate  out  1  tied 0
- bus2ip_mst_cmd_timeout  out  1  tied 0
- bus2ip_mstrd_d  out  DATA_WIDTH  read data
- bus2ip_mstrd_src_rdy_n  out  1  read data valid, active low
- bus2ip_mstwr_dst_rdy_n  out  1  write data taken, active low
- usr_rd_addr  in  log2(NUM_WORDS)  side-port word index
- usr_rd_data  out  DATA_WIDTH  side-port data, registered, 1-cycle latency
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at posedge):
  - State IDLE; all register words 0.
  - cmdack=0, cmplt=0, error=0, mstrd_d=0, src_rdy_n=1, dst_rdy_n=1, usr_rd_data=0, busy=0.
- States: IDLE, ACK, WAIT, XFER, DONE.
- IDLE, request sampled at edge T:
  - Latch addr, be, wr data and direction; go to ACK.
  - rd_req and wr_req both high: latch as read, with error forced.
- ACK: cmdack=1 for exactly one cycle (registered, visible cycle T+1). Load wait counter with RESP_LATENCY. Go to WAIT, or directly to XFER if RESP_LATENCY=0.
- WAIT: decrement the counter each cycle; go to XFER when it reaches 1.
- XFER (one cycle): cmplt=1.
  - Read: src_rdy_n=0; mstrd_d = bank word, or 0 on error.
  - Write: dst_rdy_n=0; bank word updated per byte enable (be[i] gates byte i); no update on error.
  - Completion at cycle T+2+RESP_LATENCY.
- Error (error=1 with cmplt) when any of:
  - addr < BASE_ADDR
  - word index (addr-BASE_ADDR)>>2 >= NUM_WORDS
  - addr[1:0] != 0
  - simultaneous rd+wr request
- Word index = bits [log2(NUM_WORDS)+1:2] of (addr-BASE_ADDR), after the range check.
- DONE: one turnaround cycle, all strobes deasserted; requests are not sampled here. Then IDLE.
- mstrd_d holds its value until the next read reaches XFER, since the initiator samples data the cycle after cmplt.
- Requests are ignored while busy; the initiator holds req until cmdack.
- ip2bus_mst_reset=1 in any state: next cycle IDLE, strobes deasserted, no pending write applied. The bank is not cleared.
- Side port: usr_rd_data <= bank[usr_rd_addr] each cycle. On a same-cycle bus write to that word, the side port shows the old value that cycle and the new value the next cycle.
- reset_n mid-transaction: immediate return to reset values; the write is not applied unless XFER was already completed.

Test Plan:
- Write addr=BASE+0x8, data=32'hDEADBEEF, be=4'hF, RESP_LATENCY=2, req at cycle 0 -> cmdack at cycle 1, cmplt+dst_rdy_n=0 at cycle 4, error=0; side port word 2 reads 32'hDEADBEEF.
- Read back BASE+0x8 -> cmplt+src_rdy_n=0 at cycle 4, mstrd_d=32'hDEADBEEF, still held 3 cycles later.
- Partial write be=4'b0101, data=32'h11223344 onto word 2 -> word becomes 32'hDE22BE44.
- Out-of-range read BASE+4*NUM_WORDS, then unaligned write BASE+0x5 -> both cmplt with error=1; read data 0; bank unchanged.
- Back-to-back requests, RESP_LATENCY=0: second req held from cycle 1 -> accepted only after DONE; cmdack cycles 1 and 5; cmplt cycles 2 and 6.
- mst_reset asserted during WAIT of a write -> no cmplt, word unchanged, busy=0 next cycle; reset_n=0 -> all outputs at reset values, bank reads 0.
